// File: rtl/systolic_is_feeder.sv
// systolic_is_feeder: loads N stationary rows, then streams skewed activation vectors with psum_valid strobes
module systolic_is_feeder #(
    parameter int D_W      = 8,
    parameter int N        = 4,
    parameter int K_MAX    = 256,
    parameter int SKEW_OUT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(K_MAX+1)-1:0]   num_vec,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [N*D_W-1:0]             ld_data,
    input  logic                         st_valid,
    output logic                         st_ready,
    input  logic [N*D_W-1:0]             st_data,
    output logic                         load_weight,
    output logic [N*D_W-1:0]             m1,
    output logic [N*D_W-1:0]             m0,
    output logic [N-1:0]                 psum_valid,
    output logic                         busy,
    output logic                         done
);
    localparam int VW = $clog2(K_MAX + 1);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (N + SKEW_OUT > 1) ? $clog2(N + SKEW_OUT) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;
    state_t state, state_n;

    logic [VW-1:0]         nv_q, vcnt;
    logic [RW-1:0]         rcnt;
    logic [CW-1:0]         dcnt;
    logic [SKEW_OUT+N-1:0] vec_issue;
    logic                  ld_acc, st_acc, last_row, last_vec, drained;

    assign ld_ready   = state == LOAD;
    assign st_ready   = state == STREAM;
    assign busy       = state != IDLE;
    assign ld_acc     = ld_ready && ld_valid;
    assign st_acc     = st_ready && st_valid;
    assign last_row   = ld_acc && rcnt == RW'(N - 1);
    assign last_vec   = st_acc && vcnt + VW'(1) == nv_q;
    assign drained    = state == DRAIN && dcnt == CW'(N + SKEW_OUT - 1);
    assign psum_valid = vec_issue[SKEW_OUT+N-1 -: N];

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? LOAD : IDLE;
            LOAD:    state_n = last_row ? (nv_q == '0 ? DRAIN : STREAM) : LOAD;
            STREAM:  state_n = last_vec ? DRAIN : STREAM;
            DRAIN:   state_n = drained ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            nv_q        <= '0;
            vcnt        <= '0;
            rcnt        <= '0;
            dcnt        <= '0;
            done        <= 1'b0;
            load_weight <= 1'b0;
            m1          <= '0;
            vec_issue   <= '0;
        end else begin
            if (state == IDLE && start) nv_q <= num_vec;
            if (ld_acc) rcnt <= last_row ? '0 : rcnt + RW'(1);
            if (st_acc) vcnt <= last_vec ? '0 : vcnt + VW'(1);
            dcnt        <= state == DRAIN ? dcnt + CW'(1) : '0;
            done        <= drained;
            load_weight <= ld_acc;
            if (ld_acc) m1 <= ld_data;
            vec_issue   <= {vec_issue[SKEW_OUT+N-2:0], st_acc};
        end

    // row i delays its element by i extra cycles; bubbles shift in as zeros
    for (genvar i = 0; i < N; i++) begin : g_row
        logic [D_W-1:0] line [0:i];
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                for (int k = 0; k <= i; k++) line[k] <= '0;
            end else begin
                line[0] <= st_acc ? st_data[i*D_W +: D_W] : '0;
                for (int k = 1; k <= i; k++) line[k] <= line[k-1];
            end
        assign m0[i*D_W +: D_W] = line[i];
    end
endmodule

// File: tb/tb_systolic_is_feeder.sv
// tb_systolic_is_feeder: directed and random tiles checked cycle-by-cycle against a schedule-based model
module tb_systolic_is_feeder;
    localparam int D_W = 8, N = 4, K_MAX = 256, SKEW_OUT = 4;
    localparam int VW = $clog2(K_MAX + 1);

    logic clk = 0, rst = 1, start = 0, ld_valid = 0, st_valid = 0;
    logic [VW-1:0] num_vec = '0;
    logic [N*D_W-1:0] ld_data = '0, st_data = '0;
    logic ld_ready, st_ready, load_weight, busy, done;
    logic [N*D_W-1:0] m1, m0;
    logic [N-1:0] psum_valid;

    systolic_is_feeder #(.D_W(D_W), .N(N), .K_MAX(K_MAX), .SKEW_OUT(SKEW_OUT)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .load_weight(load_weight), .m1(m1), .m0(m0), .psum_valid(psum_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;
    int t = 0;
    bit in_tile = 0;
    int rows, vecs, nv_m, done_cyc, done_seen;
    bit exp_ldr = 0, exp_str = 0;
    logic [N*D_W-1:0] exp_m1 = '0;
    logic [D_W-1:0] m0_at [64][N];
    logic [N-1:0] pv_at [64];
    bit lw_at [64];
    logic [N*D_W-1:0] m1_at [64];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, t);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 64; s++) begin
            lw_at[s] = 0; pv_at[s] = '0; m1_at[s] = '0;
            for (int i = 0; i < N; i++) m0_at[s][i] = '0;
        end
        in_tile = 0; exp_m1 = '0; exp_ldr = 0; exp_str = 0;
    endtask

    task automatic check();
        int s;
        bit eb, ed;
        logic [N*D_W-1:0] em0;
        s  = t % 64;
        eb = in_tile && t < done_cyc;
        ed = in_tile && t == done_cyc;
        if (ed) begin in_tile = 0; done_seen = t; end
        if (lw_at[s]) exp_m1 = m1_at[s];
        exp_ldr = eb && rows < N;
        exp_str = eb && rows == N && vecs < nv_m;
        for (int i = 0; i < N; i++) em0[i*D_W +: D_W] = m0_at[s][i];
        chk("busy", busy, eb);
        chk("done", done, ed);
        chk("ld_ready", ld_ready, exp_ldr);
        chk("st_ready", st_ready, exp_str);
        chk("load_weight", load_weight, lw_at[s]);
        chk("m1", m1, exp_m1);
        chk("m0", m0, em0);
        chk("psum_valid", psum_valid, pv_at[s]);
        lw_at[s] = 0; pv_at[s] = '0;
        for (int i = 0; i < N; i++) m0_at[s][i] = '0;
    endtask

    // apply the current inputs for one cycle, predict their effects, then check the next cycle
    task automatic tick();
        bit la, sa;
        la = exp_ldr && ld_valid;
        sa = exp_str && st_valid;
        if (la) begin
            lw_at[(t+1)%64] = 1;
            m1_at[(t+1)%64] = ld_data;
            rows++;
            if (rows == N && nv_m == 0) done_cyc = t + 1 + N + SKEW_OUT;
        end
        if (sa) begin
            for (int i = 0; i < N; i++) m0_at[(t+1+i)%64][i] = st_data[i*D_W +: D_W];
            for (int j = 0; j < N; j++) pv_at[(t+1+SKEW_OUT+j)%64][j] = 1'b1;
            vecs++;
            if (vecs == nv_m) done_cyc = t + 1 + N + SKEW_OUT;
        end
        if (start && !in_tile) begin
            in_tile = 1; nv_m = int'(num_vec); rows = 0; vecs = 0; done_cyc = 1 << 30;
        end
        @(posedge clk); #1; t++;
        check();
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk); #1; t++;
        clear_model();
        check();
        rst = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (in_tile && n < 200) begin tick(); n++; end
        chk("idle_timeout", in_tile, 0);
    endtask

    task automatic load_rows(logic [7:0] base);
        ld_valid = 1;
        for (int r = 0; r < N; r++) begin
            ld_data = {N{8'(int'(base) * (r + 1))}};
            tick();
        end
        ld_valid = 0;
    endtask

    task automatic run_tile(int nv, int ldp, int stp);
        int n = 0;
        start = 1; num_vec = VW'(nv);
        tick();
        start = 0;
        while (in_tile && n < 2000) begin
            ld_valid = $urandom_range(99) < ldp;
            ld_data  = {$urandom, $urandom};
            st_valid = $urandom_range(99) < stp;
            st_data  = {$urandom, $urandom};
            num_vec  = VW'($urandom_range(20));
            tick();
            n++;
        end
        ld_valid = 0; st_valid = 0;
        chk("tile_timeout", in_tile, 0);
    endtask

    initial begin
        int s0;
        clear_model();
        do_reset();
        repeat (3) tick();

        // rows 0x11..0x44 back-to-back, three vectors, spurious start and num_vec change mid-tile
        start = 1; num_vec = VW'(3); s0 = t;
        tick();
        start = 0;
        ld_valid = 1;
        for (int r = 0; r < N; r++) begin
            ld_data = {N{8'(17 * (r + 1))}};
            if (r == 1) begin start = 1; num_vec = VW'(7); end
            tick();
            start = 0;
        end
        ld_valid = 0;
        st_valid = 1;
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < N; i++) st_data[i*D_W +: D_W] = 8'(4 * v + 1 + i);
            tick();
        end
        st_valid = 0;
        wait_idle();
        chk("tile_len", done_seen - s0, 1 + N + 3 + N + SKEW_OUT);
        tick();

        // bubble: st_valid 1,0,1
        start = 1; num_vec = VW'(2);
        tick();
        start = 0;
        load_rows(8'h05);
        st_valid = 1; st_data = 32'hA4A3A2A1; tick();
        st_valid = 0; st_data = 32'hDEADBEEF; tick();
        st_valid = 1; st_data = 32'hB4B3B2B1; tick();
        st_valid = 0;
        wait_idle();

        // zero vectors: stream phase skipped even with st_valid held high
        start = 1; num_vec = '0; s0 = t;
        tick();
        start = 0;
        st_valid = 1; st_data = 32'h01020304;
        load_rows(8'h21);
        wait_idle();
        st_valid = 0;
        chk("tile_len_zero", done_seen - s0, 1 + N + N + SKEW_OUT);

        // reset after 3 of 8 vectors, then a clean tile
        start = 1; num_vec = VW'(8);
        tick();
        start = 0;
        load_rows(8'h31);
        st_valid = 1;
        for (int v = 0; v < 3; v++) begin
            st_data = {$urandom};
            tick();
        end
        st_valid = 0;
        do_reset();
        tick();
        run_tile(8, 100, 100);
        tick();

        for (int k = 0; k < 8; k++) begin
            run_tile($urandom_range(0, 12), 60, 60);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
